vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator with pixel fetch and registered colour output.
//  Timing is set by parameters, sync polarity is selectable, and the pixel clock enable
//  acts as a true clock enable (no gated clock).
//  Sits between the frame-buffer/pattern source (driven via need_pixel, pixel_x, pixel_y)
//  and the DAC/connector pins. Emits frame and line strobes for upstream sequencing.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch, pixels
//  H_SYNC     96   horizontal sync width, pixels
//  H_BP       48   horizontal back porch, pixels
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch, lines
//  V_SYNC     2    vertical sync width, lines
//  V_BP       33   vertical back porch, lines
//  H_POL      0    hsync asserted level (0 = active-low, as for 640x480@60)
//  V_POL      0    vsync asserted level
//  R_W/G_W/B_W 3/3/2  colour channel widths; colors width = R_W+G_W+B_W (R in MSBs)
// PORTS
//  clk25MHz   in   1      pixel clock
//  rst        in   1      asynchronous reset, active-high
//  en         in   1      pixel clock enable; all state advances only when en=1
//  colors     in   R_W+G_W+B_W  pixel colour, {R,G,B}, sampled on enabled edge with need_pixel=1
//  need_pixel out  1      current counter position is visible; source must present colors now
//  pixel_x    out  10     visible column of requested pixel (0..H_ACTIVE-1), 0 when not visible
//  pixel_y    out  10     visible row of requested pixel (0..V_ACTIVE-1), 0 when not visible
//  hsync      out  1      horizontal sync, polarity H_POL, registered
//  vsync      out  1      vertical sync, polarity V_POL, registered
//  de         out  1      display enable, aligned with red/green/blue, registered
//  red        out  R_W    red; 0 when de=0
//  green      out  G_W    green; 0 when de=0
//  blue       out  B_W    blue; 0 when de=0
//  line_start out  1      1-cycle pulse, aligned with output stage, at h_cnt=0
//  frame_start out 1      1-cycle pulse, aligned with output stage, at h_cnt=0 and v_cnt=0
// BEHAVIOUR
//  - H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT likewise. Counter width = $clog2(max(H_TOT,V_TOT)), max 10 bits.
//  - Line layout from h_cnt=0: active, front porch, sync, back porch. Frame layout likewise for v_cnt.
//  - Counters, on enabled edge:
//    - h_cnt increments and wraps H_TOT-1 -> 0.
//    - v_cnt increments only on the h wrap and wraps V_TOT-1 -> 0 on the same edge.
//  - Stage 0 (counter regs):
//    - need_pixel = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
//    - pixel_x/pixel_y = h_cnt/v_cnt when need_pixel=1, else 0. Combinational from regs only.
//  - Stage 1 (output regs, updated on every enabled edge):
//    - de<=need_pixel.
//    - rgb<=need_pixel ? colors : 0.
//    - hsync<=(h_cnt in sync window) ? H_POL : ~H_POL; vsync likewise.
//    - line_start<=(h_cnt==0); frame_start<=(h_cnt==0 && v_cnt==0).
//  - Latency: counter position -> pins is exactly 1 enabled cycle for sync, de, rgb and strobes.
//  - line_start/frame_start are each high for one enabled cycle. With en=0 they hold;
//    upstream logic qualifies them with en.
//  - en=0: every register holds and outputs are frozen. Phase resumes without slip when en returns.
//  - Reset (async assert, released synchronously by upstream):
//    - h_cnt=v_cnt=0; de=0; rgb=0; line_start=frame_start=0.
//    - hsync=~H_POL, vsync=~V_POL (deasserted).
//    - Combinationally during reset: need_pixel=1, pixel_x=pixel_y=0.
//    - Mid-frame reset aborts the frame. The first enabled edge after release outputs position (0,0).
//  - Elaboration: $error if any width/porch parameter is 0, or H_TOT/V_TOT > 1024.
// TESTING
//  - Defaults, en=1, run 2 frames:
//    - hsync low for 96 clocks every 800; vsync low for 2 lines every 525.
//    - de high 640 clocks/line, 480 lines/frame.
//  - Small params H=4/1/2/1, V=3/1/1/1:
//    - H_TOT=8, V_TOT=6; need_pixel at h_cnt 0..3, v_cnt 0..2.
//    - hsync asserted on pins for the cycles after h_cnt=5,6; frame_start every 48 clocks.
//  - colors=8'hE5 when (pixel_x,pixel_y)=(2,1), else 8'h00:
//    - exactly one cycle with de=1, red=3'b111, green=3'b001, blue=2'b01, one cycle after the request.
//  - en toggled 1/0 each clock:
//    - output waveform equals the en=1 waveform stretched 2x; no counter slip.
//  - rst pulsed at h_cnt=300, v_cnt=200 (defaults):
//    - outputs go to reset values immediately.
//    - first post-release edge gives frame_start=1, de=1, pixel_x=0.
//  - H_POL=1, V_POL=1:
//    - hsync/vsync are the inverse of the default run; de/rgb are unchanged.

Source files
------------

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA raster timing generator. A horizontal/vertical counter pair
//   walks the raster (active, front porch, sync, back porch). The current
//   position is exposed combinationally so a pixel source can present a colour.
//   Sync, display enable, colour and the line/frame strobes are registered one
//   enabled cycle later. All state advances only on edges where en=1, so en is
//   a true clock enable and no gated clock is needed.
//
// Ports
//   clk25MHz    in   pixel clock
//   rst         in   asynchronous reset, active-high
//   en          in   pixel clock enable
//   colors      in   {R,G,B} pixel colour, sampled while need_pixel=1
//   need_pixel  out  counter position is visible; source must present colors
//   pixel_x     out  visible column of the requested pixel, 0 when not visible
//   pixel_y     out  visible row of the requested pixel, 0 when not visible
//   hsync       out  horizontal sync, asserted level H_POL, registered
//   vsync       out  vertical sync, asserted level V_POL, registered
//   de          out  display enable, aligned with red/green/blue
//   red/green/blue out colour channels, 0 while de=0
//   line_start  out  one-enabled-cycle pulse for h_cnt=0
//   frame_start out  one-enabled-cycle pulse for h_cnt=0 and v_cnt=0
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned R_W      = 3,
  parameter int unsigned G_W      = 3,
  parameter int unsigned B_W      = 2
) (
  input  logic                     clk25MHz,
  input  logic                     rst,
  input  logic                     en,
  input  logic [R_W+G_W+B_W-1:0]   colors,
  output logic                     need_pixel,
  output logic [9:0]               pixel_x,
  output logic [9:0]               pixel_y,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     de,
  output logic [R_W-1:0]           red,
  output logic [G_W-1:0]           green,
  output logic [B_W-1:0]           blue,
  output logic                     line_start,
  output logic                     frame_start
);

  localparam int unsigned H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned MAX_TOT = (H_TOT > V_TOT) ? H_TOT : V_TOT;
  localparam int unsigned CW      = $clog2(MAX_TOT);
  localparam int unsigned CLR_W   = R_W + G_W + B_W;

  // Raster landmarks, sized to the counters so comparisons stay width-matched.
  localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_LO = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_HI = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST    = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYNC_LO = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_HI = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOT - 1);

  // Reject timings that cannot be laid out or do not fit the 10-bit position ports.
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      R_W == 0 || G_W == 0 || B_W == 0) begin : g_zero_param
    $error("vga_timing_gen: width/porch parameters must be non-zero");
  end
  if (H_TOT > 1024 || V_TOT > 1024) begin : g_too_large
    $error("vga_timing_gen: H_TOT/V_TOT must not exceed 1024");
  end

  logic [CW-1:0]    h_cnt;
  logic [CW-1:0]    v_cnt;
  logic             h_last;
  logic             v_last;
  logic             in_hsync;
  logic             in_vsync;
  logic [CLR_W-1:0] rgb_q;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // ---------------------------------------------------------------------------
  // Stage 0: raster counters
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of process ordering.
  always_ff @(posedge clk25MHz or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_last) begin
        h_cnt <= '0;
        // The vertical counter steps on the same edge the line wraps.
        v_cnt <= v_last ? '0 : v_cnt + CW'(1);
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

  assign need_pixel = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign pixel_x    = need_pixel ? 10'(h_cnt) : 10'd0;
  assign pixel_y    = need_pixel ? 10'(v_cnt) : 10'd0;

  assign in_hsync = (h_cnt >= H_SYNC_LO) && (h_cnt < H_SYNC_HI);
  assign in_vsync = (v_cnt >= V_SYNC_LO) && (v_cnt < V_SYNC_HI);

  // ---------------------------------------------------------------------------
  // Stage 1: pin registers, one enabled cycle behind the counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk25MHz or posedge rst) begin
    if (rst) begin
      de          <= 1'b0;
      rgb_q       <= '0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      de          <= need_pixel;
      // Blanking forces black so the DAC never sees stray source data.
      rgb_q       <= need_pixel ? colors : '0;
      hsync       <= in_hsync ? H_POL : ~H_POL;
      vsync       <= in_vsync ? V_POL : ~V_POL;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  assign red   = rgb_q[CLR_W-1 -: R_W];
  assign green = rgb_q[G_W+B_W-1 -: G_W];
  assign blue  = rgb_q[B_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Three instances share one clock: the default 640x480 timing, a reduced
//   8x6 raster, and the reduced raster with inverted sync polarity. A vector
//   table exercises the reduced raster from reset; hand-written sequences cover
//   whole frames, en toggling, mid-frame reset and default line timing.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small-raster pair stimulus
  logic       rst_s;
  logic       en_s;
  logic [7:0] col_s;
  // Default-raster stimulus
  logic       rst_d;
  logic       en_d;
  logic [7:0] col_d;

  // Small raster outputs
  logic       s_np, s_hs, s_vs, s_de, s_ls, s_fs;
  logic [9:0] s_px, s_py;
  logic [2:0] s_r, s_g;
  logic [1:0] s_b;
  // Small raster, inverted polarity
  logic       p_np, p_hs, p_vs, p_de, p_ls, p_fs;
  logic [9:0] p_px, p_py;
  logic [2:0] p_r, p_g;
  logic [1:0] p_b;
  // Default raster
  logic       d_np, d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_px, d_py;
  logic [2:0] d_r, d_g;
  logic [1:0] d_b;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_small (
    .clk25MHz(clk), .rst(rst_s), .en(en_s), .colors(col_s),
    .need_pixel(s_np), .pixel_x(s_px), .pixel_y(s_py),
    .hsync(s_hs), .vsync(s_vs), .de(s_de),
    .red(s_r), .green(s_g), .blue(s_b),
    .line_start(s_ls), .frame_start(s_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_small_pol (
    .clk25MHz(clk), .rst(rst_s), .en(en_s), .colors(col_s),
    .need_pixel(p_np), .pixel_x(p_px), .pixel_y(p_py),
    .hsync(p_hs), .vsync(p_vs), .de(p_de),
    .red(p_r), .green(p_g), .blue(p_b),
    .line_start(p_ls), .frame_start(p_fs)
  );

  vga_timing_gen u_default (
    .clk25MHz(clk), .rst(rst_d), .en(en_d), .colors(col_d),
    .need_pixel(d_np), .pixel_x(d_px), .pixel_y(d_py),
    .hsync(d_hs), .vsync(d_vs), .de(d_de),
    .red(d_r), .green(d_g), .blue(d_b),
    .line_start(d_ls), .frame_start(d_fs)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Vector record: stage-0 view before the edge, stage-1 pins after it.
  typedef struct {
    logic       en;
    logic [7:0] colors;
    logic       np;
    logic [9:0] px;
    logic [9:0] py;
    logic       de;
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } vec_t;

  vec_t vecs[13];

  // Small-raster reference model state (position of stage 0, expected pins).
  int   mh, mv;
  logic e_de, e_hs, e_vs, e_ls, e_fs;
  logic [7:0] e_rgb;
  // Default-raster reference model state.
  int   dh, dv;
  logic f_de, f_hs, f_vs, f_ls, f_fs;
  logic [7:0] f_rgb;

  task automatic check_reset_small(input string tag);
    check({tag, " small np/x/y"}, 32'({s_np, s_px, s_py}), 32'({1'b1, 10'd0, 10'd0}));
    check({tag, " small pins"}, 32'({s_de, s_r, s_g, s_b, s_hs, s_vs, s_ls, s_fs}),
          32'({1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}));
    check({tag, " pol pins"}, 32'({p_de, p_r, p_g, p_b, p_hs, p_vs, p_ls, p_fs}),
          32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}));
  endtask

  task automatic check_reset_default(input string tag);
    check({tag, " default np/x/y"}, 32'({d_np, d_px, d_py}), 32'({1'b1, 10'd0, 10'd0}));
    check({tag, " default pins"}, 32'({d_de, d_r, d_g, d_b, d_hs, d_vs, d_ls, d_fs}),
          32'({1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}));
  endtask

  // Asynchronous reset pulse on the small pair, asserted away from any edge.
  task automatic pulse_reset_small(input string tag);
    @(posedge clk);
    #3 rst_s = 1'b1;
    #1 check_reset_small(tag);
    @(negedge clk);
    @(negedge clk);
    rst_s = 1'b0;
    en_s  = 1'b0;
    mh = 0; mv = 0;
    e_de = 1'b0; e_rgb = 8'h00; e_hs = 1'b1; e_vs = 1'b1; e_ls = 1'b0; e_fs = 1'b0;
  endtask

  task automatic run_small(input int cycles, input bit toggle, input int exp_e5);
    int   e5 = 0;
    logic exp_np;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      en_s   = toggle ? (c % 2 == 0) : 1'b1;
      col_s  = (mh == 2 && mv == 1) ? 8'hE5 : 8'h00;
      exp_np = (mh < 4) && (mv < 3);
      check("small stage0", 32'({s_np, s_px, s_py}),
            32'({exp_np, exp_np ? 10'(mh) : 10'd0, exp_np ? 10'(mv) : 10'd0}));
      if (en_s) begin
        e_de  = exp_np;
        e_rgb = exp_np ? col_s : 8'h00;
        e_hs  = !(mh == 5 || mh == 6);
        e_vs  = !(mv == 4);
        e_ls  = (mh == 0);
        e_fs  = (mh == 0) && (mv == 0);
        if (mh == 7) begin
          mh = 0;
          mv = (mv == 5) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
      @(posedge clk);
      #1;
      check("small pins", 32'({s_de, s_r, s_g, s_b, s_hs, s_vs, s_ls, s_fs}),
            32'({e_de, e_rgb, e_hs, e_vs, e_ls, e_fs}));
      check("pol pins", 32'({p_de, p_r, p_g, p_b, p_hs, p_vs, p_ls, p_fs}),
            32'({e_de, e_rgb, ~e_hs, ~e_vs, e_ls, e_fs}));
      if (en_s && s_de && {s_r, s_g, s_b} == 8'hE5) e5++;
    end
    check("E5 pixel count", 32'(e5), 32'(exp_e5));
  endtask

  task automatic run_default(input int cycles, input int exp_hs_low, input int exp_de);
    int   hs_low = 0;
    int   de_cnt = 0;
    logic exp_np;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      en_d   = 1'b1;
      col_d  = 8'hA7;
      exp_np = (dh < 640) && (dv < 480);
      check("default stage0", 32'({d_np, d_px, d_py}),
            32'({exp_np, exp_np ? 10'(dh) : 10'd0, exp_np ? 10'(dv) : 10'd0}));
      f_de  = exp_np;
      f_rgb = exp_np ? col_d : 8'h00;
      f_hs  = !(dh >= 656 && dh < 752);
      f_vs  = !(dv >= 490 && dv < 492);
      f_ls  = (dh == 0);
      f_fs  = (dh == 0) && (dv == 0);
      if (dh == 799) begin
        dh = 0;
        dv = (dv == 524) ? 0 : dv + 1;
      end else begin
        dh = dh + 1;
      end
      @(posedge clk);
      #1;
      check("default pins", 32'({d_de, d_r, d_g, d_b, d_hs, d_vs, d_ls, d_fs}),
            32'({f_de, f_rgb, f_hs, f_vs, f_ls, f_fs}));
      if (!d_hs) hs_low++;
      if (d_de) de_cnt++;
    end
    check("default hsync low count", 32'(hs_low), 32'(exp_hs_low));
    check("default de count", 32'(de_cnt), 32'(exp_de));
  endtask

  initial begin
    rst_s = 1'b0; en_s = 1'b0; col_s = 8'h00;
    rst_d = 1'b0; en_d = 1'b0; col_d = 8'h00;

    // Power-on reset: outputs at reset values while rst is high.
    #2 rst_s = 1'b1; rst_d = 1'b1;
    #1;
    check_reset_small("por");
    check_reset_default("por");
    @(negedge clk);
    @(negedge clk);
    rst_s = 1'b0;
    rst_d = 1'b0;

    //              en    colors  np    px     py     de    rgb    hs    vs    ls    fs
    vecs[0]  = '{1'b1, 8'h11, 1'b1, 10'd0, 10'd0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 8'h22, 1'b1, 10'd1, 10'd0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'hE5, 1'b1, 10'd2, 10'd0, 1'b1, 8'hE5, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h44, 1'b1, 10'd3, 10'd0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'hFF, 1'b0, 10'd0, 10'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'hFF, 1'b0, 10'd0, 10'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'hFF, 1'b0, 10'd0, 10'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'hFF, 1'b0, 10'd0, 10'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h55, 1'b1, 10'd0, 10'd1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h66, 1'b1, 10'd0, 10'd1, 1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h77, 1'b1, 10'd1, 10'd1, 1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 8'h3C, 1'b1, 10'd1, 10'd1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'hE5, 1'b1, 10'd2, 10'd1, 1'b1, 8'hE5, 1'b1, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      en_s  = vecs[i].en;
      col_s = vecs[i].colors;
      check($sformatf("vec%0d stage0", i), 32'({s_np, s_px, s_py}),
            32'({vecs[i].np, vecs[i].px, vecs[i].py}));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d pins", i),
            32'({s_de, s_r, s_g, s_b, s_hs, s_vs, s_ls, s_fs}),
            32'({vecs[i].de, vecs[i].rgb, vecs[i].hs, vecs[i].vs, vecs[i].ls, vecs[i].fs}));
    end

    // Whole frames on the small raster, then the same with en toggling.
    pulse_reset_small("pre-run");
    run_small(96, 1'b0, 2);
    run_small(96, 1'b1, 1);
    run_small(19, 1'b0, 1);
    // Mid-frame reset (h=3, v=2): immediate reset values, clean restart at (0,0).
    pulse_reset_small("mid-frame");
    run_small(4, 1'b0, 0);

    // Default timing: three full lines, then partway into the fourth.
    dh = 0; dv = 0;
    run_default(800, 96, 640);
    run_default(800, 96, 640);
    run_default(800, 96, 640);
    run_default(300, 0, 300);
    @(posedge clk);
    #3 rst_d = 1'b1;
    #1 check_reset_default("default mid-line");
    @(negedge clk);
    @(negedge clk);
    rst_d = 1'b0;
    en_d  = 1'b0;
    dh = 0; dv = 0;
    run_default(2, 0, 2);
    check("default first strobes", 32'({d_ls, d_fs}), 32'({1'b0, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
